// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: nibble-serial wide adder controller.
// One shared 4-bit ripple adder (sum4b) is stepped over NIBBLES cycles,
// LSB nibble first, with the carry kept in a register between steps.
// Optional feature macro: SUB_EN (enables A-B via the sub input).

module sum4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    logic [4:0] c;

    assign c[0] = ci;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign co = c[4];
endmodule

module add_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 CI,
    input  logic                 sub,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] Sum,
    output logic                 Cout,
    output logic                 Ovf
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_reg, state_next;
    logic [W-1:0]    a_reg, b_reg, acc_reg, sum_reg;
    logic            carry_reg, cout_reg, ovf_reg;
    logic [IW-1:0]   idx_reg;
    logic            busy_reg, busy_next, done_reg, done_next;

    logic [W-1:0]    b_eff;
    logic            carry0;
    logic [3:0]      a_nib [NIBBLES];
    logic [3:0]      b_nib [NIBBLES];
    logic [3:0]      nib_a, nib_b, nib_s;
    logic            nib_co;
    logic            last_nib;
    logic [W-1:0]    acc_shift;

    // Operand conditioning at capture: subtraction is A + ~B + 1.
`ifdef SUB_EN
    assign b_eff  = sub ? ~B : B;
    assign carry0 = sub ? 1'b1 : CI;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff      = B;
    assign carry0     = CI;
`endif

    // Slice the captured operands into nibbles for the per-cycle select.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[4*gi +: 4];
            assign b_nib[gi] = b_reg[4*gi +: 4];
        end
    endgenerate

    assign nib_a     = a_nib[idx_reg];
    assign nib_b     = b_nib[idx_reg];
    assign last_nib  = (idx_reg == IW'(NIBBLES - 1));
    // New nibble enters at the top; after NIBBLES shifts nibble 0 sits at the bottom.
    assign acc_shift = {nib_s, acc_reg[W-1:4]};

    sum4b u_sum4b (
        .a  (nib_a),
        .b  (nib_b),
        .ci (carry_reg),
        .s  (nib_s),
        .co (nib_co)
    );

    // State register plus registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic; status flags are derived from the next state so they register cleanly.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_nib) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
        done_next = (state_next == DONE);
    end

    // Datapath: operand capture, nibble stepping and final result write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= A;
                        b_reg     <= b_eff;
                        carry_reg <= carry0;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    acc_reg   <= acc_shift;
                    carry_reg <= nib_co;
                    idx_reg   <= idx_reg + 1'b1;
                    if (last_nib) begin
                        sum_reg  <= acc_shift;
                        cout_reg <= nib_co;
                        // Sign of the result is the top bit of the last nibble.
                        ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) && (nib_s[3] != a_reg[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign Sum  = sum_reg;
    assign Cout = cout_reg;
    assign Ovf  = ovf_reg;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl (NIBBLES=4) with a result scoreboard.
module tb_add_seq_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         CI = 1'b0;
    logic         sub = 1'b0;
    logic         busy, done, Cout, Ovf;
    logic [W-1:0] Sum;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    add_seq_ctrl #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .CI    (CI),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Cout  (Cout),
        .Ovf   (Ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic s);
        exp_t         e;
        logic [W:0]   t;
        logic [W-1:0] bp;
        logic         c0;
`ifdef SUB_EN
        bp = s ? ~b : b;
        c0 = s ? 1'b1 : ci;
`else
        bp = b;
        c0 = ci;
        if (s) bp = b;
`endif
        t      = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, c0};
        e.sum  = t[W-1:0];
        e.cout = t[W];
        e.ovf  = (a[W-1] == bp[W-1]) && (t[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation: start at edge k, then check every cycle through busy falling.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic s, input bit inject);
        exp_t e;
        @(negedge clk);
        A = a; B = b; CI = ci; sub = s; start = 1'b1;
        sb.push_back(model(a, b, ci, s));
        @(posedge clk); #1;
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); CI = ~ci; sub = ~s;
        check("busy_after_start", 32'(busy), 32'd1);
        check("done_after_start", 32'(done), 32'd0);
        for (int c = 1; c < N; c++) begin
            @(posedge clk); #1;
            check($sformatf("busy_run%0d", c), 32'(busy), 32'd1);
            check($sformatf("done_run%0d", c), 32'(done), 32'd0);
            if (inject && c == 1) begin
                start = 1'b1; A = 16'h1111; B = 16'h1111;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_in_done", 32'(busy), 32'd1);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(sb.size()), 32'd1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        check($sformatf("sum a=%0h b=%0h", a, b), 32'(Sum), 32'(e.sum));
        check($sformatf("cout a=%0h b=%0h", a, b), 32'(Cout), 32'(e.cout));
        check($sformatf("ovf a=%0h b=%0h", a, b), 32'(Ovf), 32'(e.ovf));
        @(posedge clk); #1;
        check("done_cleared", 32'(done), 32'd0);
        check("busy_cleared", 32'(busy), 32'd0);
        check("sum_held", 32'(Sum), 32'(e.sum));
        @(posedge clk); #1;
        check("no_second_done", 32'(done), 32'd0);
        $display("op a=%04h b=%04h ci=%0b sub=%0b -> Sum=%04h Cout=%0b Ovf=%0b",
                 a, b, ci, s, Sum, Cout, Ovf);
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(Sum),  32'd0);
        check("rst_cout", 32'(Cout), 32'd0);
        check("rst_ovf",  32'(Ovf),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        do_op(16'h00FF, 16'h0F00, 1'b1, 1'b0, 1'b0);
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
        // Second start while busy must be ignored.
        do_op(16'h2468, 16'h1357, 1'b0, 1'b0, 1'b1);

        // Abort mid-RUN with reset; no done and no result expected.
        @(negedge clk);
        A = 16'h4321; B = 16'h1111; CI = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum",  32'(Sum),  32'd0);
        check("abort_cout", 32'(Cout), 32'd0);
        check("abort_ovf",  32'(Ovf),  32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("abort_nodone%0d", c), 32'(done), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("abort during RUN: outputs cleared");
        do_op(16'h0ABC, 16'h0111, 1'b1, 1'b0, 1'b0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
